// File: rtl/alu_issue.sv
// Operand-issue stage: decodes MIPS words into ALU opcode/operands; 1-cycle latency, registered in_ready with a skid entry so stalls never drop work.
// Optional ALU_ISSUE_STATS_EN adds stat_issued (wrapping) and stat_illegal (saturating) transfer counters.
module alu_issue (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] rs_val,
    input  logic [31:0] rt_val,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_opcode,
    output logic [31:0] out_a,
    output logic [31:0] out_b,
    output logic [4:0]  out_rd,
    output logic        out_we,
    output logic        out_illegal
`ifdef ALU_ISSUE_STATS_EN
    ,
    output logic [31:0] stat_issued,
    output logic [15:0] stat_illegal
`endif
);

    typedef struct packed {
        logic [3:0]  opcode;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        we;
        logic        illegal;
    } req_t;

    typedef enum logic {PASS = 1'b0, HOLD = 1'b1} state_t;

    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd2, OP_OR  = 4'd3,
                           OP_XOR = 4'd4, OP_LUI = 4'd5, OP_SLL = 4'd6, OP_SRL = 4'd7,
                           OP_SRA = 4'd8;

    logic [5:0]  op;
    logic [5:0]  funct;
    logic [15:0] imm;
    req_t        dec;
    logic        dec_ok;

    assign op    = instr[31:26];
    assign funct = instr[5:0];
    assign imm   = instr[15:0];

    always_comb begin
        dec    = '0;
        dec_ok = 1'b1;
        if (op == 6'h00) begin
            dec.a  = rs_val;
            dec.b  = rt_val;
            dec.rd = instr[15:11];
            case (funct)
                6'h20, 6'h21: dec.opcode = OP_ADD;
                6'h22, 6'h23: dec.opcode = OP_SUB;
                6'h24:        dec.opcode = OP_AND;
                6'h25:        dec.opcode = OP_OR;
                6'h26:        dec.opcode = OP_XOR;
                6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07: begin
                    // funct[1:0] picks the shift kind; funct[2] picks variable vs immediate amount
                    case (funct[1:0])
                        2'b00:   dec.opcode = OP_SLL;
                        2'b10:   dec.opcode = OP_SRL;
                        default: dec.opcode = OP_SRA;
                    endcase
                    dec.a = rt_val;
                    dec.b = funct[2] ? {27'b0, rs_val[4:0]} : {27'b0, instr[10:6]};
                end
                default: dec_ok = 1'b0;
            endcase
        end else begin
            dec.a  = rs_val;
            dec.rd = instr[20:16];
            case (op)
                6'h08, 6'h09: begin dec.opcode = OP_ADD; dec.b = {{16{imm[15]}}, imm}; end
                6'h0C:        begin dec.opcode = OP_AND; dec.b = {16'h0, imm}; end
                6'h0D:        begin dec.opcode = OP_OR;  dec.b = {16'h0, imm}; end
                6'h0E:        begin dec.opcode = OP_XOR; dec.b = {16'h0, imm}; end
                6'h0F:        begin dec.opcode = OP_LUI; dec.a = {imm, 16'h0}; dec.b = '0; end
                default:      dec_ok = 1'b0;
            endcase
        end
        if (!dec_ok) begin
            dec = '0;
        end
        dec.illegal = !dec_ok;
        dec.we      = dec_ok && (dec.rd != 5'd0);
    end

    state_t state_q, state_d;
    logic   out_valid_q, out_valid_d;
    req_t   out_q, out_d;
    req_t   skid_q, skid_d;
    logic   accept;
    logic   out_xfer;

    assign accept   = in_valid && (state_q == PASS);
    assign out_xfer = out_valid_q && out_ready;

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        out_d       = out_q;
        skid_d      = skid_q;
        case (state_q)
            PASS: begin
                if (accept) begin
                    if (!out_valid_q || out_ready) begin
                        out_d       = dec;
                        out_valid_d = 1'b1;
                    end else begin
                        skid_d  = dec;
                        state_d = HOLD;
                    end
                end else if (out_xfer) begin
                    out_valid_d = 1'b0;
                end
            end
            HOLD: begin
                if (out_xfer) begin
                    out_d   = skid_q;
                    state_d = PASS;
                end
            end
            default: state_d = PASS;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= PASS;
            out_valid_q <= 1'b0;
            out_q       <= '0;
            skid_q      <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            out_q       <= out_d;
            skid_q      <= skid_d;
        end
    end

    assign in_ready    = (state_q == PASS);
    assign out_valid   = out_valid_q;
    assign out_opcode  = out_q.opcode;
    assign out_a       = out_q.a;
    assign out_b       = out_q.b;
    assign out_rd      = out_q.rd;
    assign out_we      = out_q.we;
    assign out_illegal = out_q.illegal;

`ifdef ALU_ISSUE_STATS_EN
    logic [31:0] stat_issued_q, stat_issued_d;
    logic [15:0] stat_illegal_q, stat_illegal_d;

    always_comb begin
        stat_issued_d  = stat_issued_q;
        stat_illegal_d = stat_illegal_q;
        if (out_xfer) begin
            stat_issued_d = stat_issued_q + 32'd1;
            if (out_q.illegal && (stat_illegal_q != 16'hFFFF)) begin
                stat_illegal_d = stat_illegal_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_issued_q  <= '0;
            stat_illegal_q <= '0;
        end else begin
            stat_issued_q  <= stat_issued_d;
            stat_illegal_q <= stat_illegal_d;
        end
    end

    assign stat_issued  = stat_issued_q;
    assign stat_illegal = stat_illegal_q;
`endif

endmodule
